piso_serializer: RTL
====================

Name: piso_serializer

Overview:
- Parallel-in serial-out transmitter: accepts one WIDTH-bit word per valid/ready handshake and shifts it out one bit per accepted serial beat.
- Serial side carries valid/ready, first and last framing markers.
- Feeds a serial link or the matching serial-in parallel-out receiver.
- Supports back-to-back words with no idle gap, and downstream backpressure.

Parameters:
- WIDTH, 4, word width in bits; legal range WIDTH >= 2.
- MSB_FIRST, 1, 1 = din[WIDTH-1] transmitted first; 0 = din[0] transmitted first.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  asynchronous, active-low reset; 0 = reset asserted.
- din  input  WIDTH  parallel word; sampled only on load acceptance.
- load_valid  input  1  upstream presents din.
- load_ready  output  1  block can accept a word this cycle.
- sout  output  1  serial data bit.
- sout_valid  output  1  sout holds a valid bit.
- sout_ready  input  1  downstream accepts the current bit.
- sout_first  output  1  current bit is the first bit of a word.
- sout_last  output  1  current bit is the last bit of a word.
- busy  output  1  a word is in flight (state SHIFT).

Behaviour:
- State machine, two states:
  - IDLE -> SHIFT on load acceptance.
  - SHIFT -> IDLE on last-bit acceptance with no new load.
  - SHIFT -> SHIFT (reload) on last-bit acceptance with a simultaneous load.
- Internal state: shift register shreg[WIDTH-1:0]; bit counter cnt of width clog2(WIDTH); cnt counts 0..WIDTH-1 with no wrap beyond.
- Reset, asserted asynchronously while rst=0:
  - state=IDLE, shreg=0, cnt=0.
  - sout=0, sout_valid=0, sout_first=0, sout_last=0, busy=0.
  - load_ready=1 once rst is released; no load is accepted while rst=0.
- Derived signals:
  - beat = sout_valid & sout_ready.
  - load_ready = (state==IDLE) | (beat & cnt==WIDTH-1); combinational.
  - load = load_valid & load_ready.
- On load at a rising edge:
  - shreg<=din, cnt<=0, state<=SHIFT.
  - Next cycle: sout_valid=1, sout_first=1, and sout = first bit of din per MSB_FIRST.
  - Latency from load edge to first bit visible: 1 cycle.
- On beat with cnt<WIDTH-1:
  - shreg shifts toward the output end (left when MSB_FIRST=1, right otherwise), zero fill; cnt<=cnt+1.
- On beat with cnt==WIDTH-1:
  - If load in the same cycle: reload as above; the new word's first bit follows the previous last bit with no gap.
  - Otherwise: state<=IDLE, cnt<=0, sout_valid<=0.
- sout_valid=0 pauses the serial side without losing data (there is no beat).
- sout_ready=0 stalls: sout, sout_first, sout_last, cnt and shreg are all held; sout_valid stays 1. The valid-before-ready rule holds: sout_valid never depends on sout_ready.
- Output timing and encoding:
  - sout is taken directly from the shreg output-end bit and is registered.
  - sout_first = sout_valid & (cnt==0).
  - sout_last = sout_valid & (cnt==WIDTH-1).
  - busy = (state==SHIFT).
  - In IDLE, sout=0.
- While in SHIFT and not on the last beat: load_ready=0, load_valid is ignored, and din changes have no effect.
- Reset mid-word: the word is abandoned, all outputs drop to their reset values immediately, and there is no partial resumption after release.

Test Plan:
- Single word, WIDTH=4, MSB_FIRST=1, sout_ready=1, din=4'b1011 loaded at edge 0:
  - sout=1,0,1,1 in cycles 1-4.
  - sout_first=1 only in cycle 1; sout_last=1 only in cycle 4.
  - load_ready=1 in cycle 4; busy=0 and sout_valid=0 in cycle 5.
- Back-to-back, din=4'hA then 4'h5 held with load_valid=1, sout_ready=1:
  - 8 contiguous bits 1,0,1,0,0,1,0,1 with sout_valid=1 throughout.
  - Second load accepted in cycle 4; sout_first=1 in cycles 1 and 5.
- Backpressure, din=4'b1100, sout_ready=0 during cycles 2-4:
  - sout=1 held with sout_valid=1 in cycles 2-4.
  - Sequence resumes 0,0 after ready returns; 4 beats total and sout_last only on the final beat.
- LSB-first, MSB_FIRST=0, din=4'b0001:
  - sout=1,0,0,0; sout_first coincides with the 1.
- Load while busy: a second load_valid with din=4'hF asserted in cycle 2 of word 4'h0:
  - load_ready=0 and the word is ignored; sout=0,0,0,0.
  - 4'hF is accepted only in cycle 4.
- Reset mid-word: rst driven to 0 in cycle 2 of word 4'b1111:
  - sout_valid, sout and busy are 0 before the next edge.
  - After release: load_ready=1 and no residual bits are emitted.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: one WIDTH-bit word per load handshake,
// shifted out one bit per accepted serial beat with first/last framing.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             sout_first,
  output logic             sout_last,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             beat;
  logic             at_last;
  logic             load;
  logic             out_bit;

  // Handshakes: a beat/load happens on a cycle where valid and ready are both
  // high at the rising edge. sout_valid depends only on registered state,
  // never on sout_ready; load_ready may depend on sout_ready so that a new
  // word can be taken on the same edge that retires the previous last bit.
  assign at_last    = (cnt == CNT_LAST);
  assign sout_valid = (state == SHIFT);
  assign beat       = sout_valid & sout_ready;
  assign load_ready = (state == IDLE) | (beat & at_last);
  assign load       = load_valid & load_ready;

  assign out_bit    = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
  assign sout       = sout_valid & out_bit;
  assign sout_first = sout_valid & (cnt == '0);
  assign sout_last  = sout_valid & at_last;
  assign busy       = (state == SHIFT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    if (load) begin
      state_nxt = SHIFT;
      shreg_nxt = din;
      cnt_nxt   = '0;
    end else if (beat) begin
      if (at_last) begin
        // Clearing the register keeps sout at 0 while idle.
        state_nxt = IDLE;
        shreg_nxt = '0;
        cnt_nxt   = '0;
      end else begin
        shreg_nxt = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
        cnt_nxt   = cnt + CW'(1);
      end
    end
  end

endmodule
